// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the sequential digital lock.
package seq_lock_pkg;

  // Lock FSM states.
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } lock_state_e;

  // Upper bounds for the generic digit extractor. Any legal parameter
  // combination of the lock must fit inside these.
  localparam int MAX_CODE_W  = 256;
  localparam int MAX_DIGIT_W = 32;

  // Total code width for a given digit width and code length.
  function automatic int code_width(input int digit_w, input int code_len);
    return digit_w * code_len;
  endfunction

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of the shared down-counter. It is loaded with cycles-1, so
  // $clog2 of the larger duration is enough (minimum 1 bit).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Digit idx of a code vector, MSB-first: idx 0 is the first digit entered.
  function automatic logic [MAX_DIGIT_W-1:0] digit_at(
    input logic [MAX_CODE_W-1:0] code,
    input int unsigned           code_len,
    input int unsigned           digit_w,
    input int unsigned           idx
  );
    logic [MAX_CODE_W-1:0] shifted;
    logic [MAX_CODE_W-1:0] mask;
    shifted = code >> ((code_len - 1 - idx) * digit_w);
    mask    = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
    return MAX_DIGIT_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
// Those two states never overlap, so one counter serves both.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_lock_fsm.sv
// Sequential digital lock. Digits arrive one per digit_valid strobe and are
// compared against a reloadable stored code. A wrong attempt is only reported
// once all CODE_LEN digits are in; MAX_TRIES consecutive failures force a
// timed lockout, a correct code opens the lock for a timed window.
//
// Handshake: digit_in is consumed on every rising edge where digit_valid=1
// and the lock is LOCKED with no relock; there is no back-pressure, digits
// presented in UNLOCKED or LOCKOUT are dropped.
module seq_lock_fsm
  import seq_lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES   = 3,
  parameter int UNLOCK_CYC  = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIGIT_W-1:0]              digit_in,
  input  logic                            digit_valid,
  input  logic                            code_load,
  input  logic [CODE_LEN*DIGIT_W-1:0]     code_in,
  input  logic                            relock,
  output logic                            unlock,
  output logic                            lockout,
  output logic                            fail_pulse,
  output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);

  localparam int CODE_W  = code_width(DIGIT_W, CODE_LEN);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int TIMER_W = timer_width(UNLOCK_CYC, LOCKOUT_CYC);

  localparam logic [TRIES_W-1:0] TRIES_FULL  = TRIES_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]   LAST_IDX    = CNT_W'(CODE_LEN - 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LD   = TIMER_W'(UNLOCK_CYC - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LD  = TIMER_W'(LOCKOUT_CYC - 1);

  // Registered state.
  lock_state_e          state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mm_q, mm_d;
  logic                 fail_q, fail_d;
  logic                 unlock_q;
  logic                 lockout_q;

  // Datapath helpers.
  logic [DIGIT_W-1:0]   cur_digit;
  logic                 mm_next;
  logic [TRIES_W-1:0]   tries_dec;

  // Timer control.
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_load_val;
  logic                 tmr_en;
  logic                 tmr_zero;

  lock_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Expected digit for the current position of the attempt.
  assign cur_digit = DIGIT_W'(digit_at(MAX_CODE_W'(code_q), 32'(CODE_LEN),
                                       32'(DIGIT_W), 32'(cnt_q)));

  // Next-state, datapath and timer control; every target defaulted first.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    tries_d      = tries_q;
    cnt_d        = cnt_q;
    mm_d         = mm_q;
    fail_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    mm_next      = mm_q | (digit_in != cur_digit);
    tries_dec    = (tries_q == '0) ? '0 : (tries_q - TRIES_W'(1));

    unique case (state_q)
      LOCKED: begin
        if (relock) begin
          // Abort the partial attempt; failures so far still count.
          cnt_d = '0;
          mm_d  = 1'b0;
        end else if (digit_valid) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            mm_d  = 1'b0;
            if (!mm_next) begin
              state_d      = UNLOCKED;
              tries_d      = TRIES_FULL;
              tmr_load     = 1'b1;
              tmr_load_val = UNLOCK_LD;
            end else begin
              fail_d  = 1'b1;
              tries_d = tries_dec;
              if (tries_dec == '0) begin
                state_d      = LOCKOUT;
                tmr_load     = 1'b1;
                tmr_load_val = LOCKOUT_LD;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            mm_d  = mm_next;
          end
        end
      end

      UNLOCKED: begin
        // A code write does not disturb the open window.
        if (code_load) begin
          code_d = code_in;
        end
        if (relock || tmr_zero) begin
          state_d = LOCKED;
        end else begin
          tmr_en = 1'b1;
        end
      end

      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = LOCKED;
          tries_d = TRIES_FULL;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = LOCKED;
      end
    endcase
  end

  // State and output registers; outputs follow the next state so that
  // unlock/lockout rise in the cycle right after the deciding edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOCKED;
      code_q    <= DEFAULT_CODE;
      tries_q   <= TRIES_FULL;
      cnt_q     <= '0;
      mm_q      <= 1'b0;
      fail_q    <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      tries_q   <= tries_d;
      cnt_q     <= cnt_d;
      mm_q      <= mm_d;
      fail_q    <= fail_d;
      unlock_q  <= (state_d == UNLOCKED);
      lockout_q <= (state_d == LOCKOUT);
    end
  end

  assign unlock     = unlock_q;
  assign lockout    = lockout_q;
  assign fail_pulse = fail_q;
  assign tries_left = tries_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_lock_fsm.sv
// Bench for seq_lock_fsm: a per-cycle expected output word is queued by the
// driver for every clock edge, and a negedge monitor pops and compares it.
// Directed segment checks (window lengths, tries, counts) use hand values.
module tb_seq_lock_fsm;

  localparam int W = 8;  // {unlock, lockout, fail, tries[1:0], cnt[2:0]}

  localparam int S_LK  = 0;
  localparam int S_UNL = 1;
  localparam int S_LO  = 2;

  // Clock/reset and DUT signals.
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        digit_valid = 1'b0;
  logic        code_load = 1'b0;
  logic [15:0] code_in = '0;
  logic        relock = 1'b0;
  logic        unlock;
  logic        lockout;
  logic        fail_pulse;
  logic [1:0]  tries_left;
  logic [2:0]  digit_cnt;

  always #5 clk = ~clk;

  seq_lock_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .code_load   (code_load),
    .code_in     (code_in),
    .relock      (relock),
    .unlock      (unlock),
    .lockout     (lockout),
    .fail_pulse  (fail_pulse),
    .tries_left  (tries_left),
    .digit_cnt   (digit_cnt)
  );

  // Scoreboard.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Reference behaviour.
  int          m_st;
  int          m_rem;
  int          m_tries;
  int          m_cnt;
  logic        m_mm;
  logic [15:0] m_code;

  // Segment measurements.
  int u_run, l_run, f_run;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_runs();
    u_run = 0;
    l_run = 0;
    f_run = 0;
  endtask

  // One clock edge with the given inputs; queues the expected outputs.
  task automatic cyc(input logic dv, input logic [3:0] d, input logic cl,
                     input logic [15:0] ci, input logic rl);
    logic       f;
    logic       mm2;
    logic [3:0] want;
    digit_valid = dv;
    digit_in    = d;
    code_load   = cl;
    code_in     = ci;
    relock      = rl;
    f = 1'b0;
    case (m_st)
      S_LK: begin
        if (rl) begin
          m_cnt = 0;
          m_mm  = 1'b0;
        end else if (dv) begin
          want = m_code[15 - 4*m_cnt -: 4];
          mm2  = m_mm | (d != want);
          if (m_cnt == 3) begin
            m_cnt = 0;
            m_mm  = 1'b0;
            if (!mm2) begin
              m_st = S_UNL; m_rem = 8; m_tries = 3;
            end else begin
              f = 1'b1;
              m_tries = m_tries - 1;
              if (m_tries == 0) begin
                m_st = S_LO; m_rem = 16;
              end
            end
          end else begin
            m_cnt = m_cnt + 1;
            m_mm  = mm2;
          end
        end
      end
      S_UNL: begin
        if (cl) m_code = ci;
        m_rem = m_rem - 1;
        if (rl || m_rem == 0) m_st = S_LK;
      end
      default: begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_st = S_LK; m_tries = 3;
        end
      end
    endcase
    exp_q.push_back({m_st == S_UNL, m_st == S_LO, f, 2'(m_tries), 3'(m_cnt)});
    @(posedge clk);
    #1;
    if (unlock) u_run++;
    if (lockout) l_run++;
    if (fail_pulse) f_run++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic dig(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic enter(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) dig(c[4*i +: 4]);
  endtask

  task automatic do_relock();
    cyc(1'b0, 4'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic load(input logic [15:0] c);
    cyc(1'b0, 4'h0, 1'b1, c, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    digit_valid = 1'b0;
    code_load = 1'b0;
    relock = 1'b0;
    m_st = S_LK; m_rem = 0; m_tries = 3; m_cnt = 0; m_mm = 1'b0;
    m_code = 16'h1234;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 2'd3, 3'd0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected word per edge, compared away from the edge.
  logic [W-1:0] mon_e, mon_a;
  always @(negedge clk) begin
    cyc_no++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {unlock, lockout, fail_pulse, tries_left, digit_cnt};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs cycle %0d got u=%b lo=%b f=%b t=%0d c=%0d expected u=%b lo=%b f=%b t=%0d c=%0d",
                 cyc_no, mon_a[7], mon_a[6], mon_a[5], mon_a[4:3], mon_a[2:0],
                 mon_e[7], mon_e[6], mon_e[5], mon_e[4:3], mon_e[2:0]);
      end
    end
  end

  // Directed sequence.
  initial begin
    do_reset();
    do_reset();
    chk("reset_tries", int'(tries_left), 3);
    chk("reset_unlock", int'(unlock), 0);

    // Correct code: 8-cycle window, no failure.
    clr_runs();
    enter(16'h1234);
    idle(10);
    chk("unlock_len", u_run, 8);
    chk("no_fail_on_match", f_run, 0);
    chk("tries_after_match", int'(tries_left), 3);

    // Wrong code once, then into lockout; digits during lockout ignored.
    clr_runs();
    enter(16'h1235);
    idle(1);
    chk("one_fail_pulse", f_run, 1);
    chk("tries_after_fail", int'(tries_left), 2);
    chk("no_unlock_on_fail", u_run, 0);
    enter(16'h1235);
    clr_runs();
    enter(16'h1235);
    enter(16'h1234);
    idle(16);
    chk("lockout_len", l_run, 16);
    chk("no_unlock_in_lockout", u_run, 0);
    chk("tries_after_lockout", int'(tries_left), 3);

    // Relock three cycles into the window.
    clr_runs();
    enter(16'h1234);
    idle(2);
    do_relock();
    chk("relock_window", u_run, 3);
    chk("relock_unlock_low", int'(unlock), 0);

    // Relock aborts a partial attempt without costing a try.
    dig(4'h1);
    dig(4'h2);
    do_relock();
    chk("abort_cnt", int'(digit_cnt), 0);
    enter(16'h1234);
    chk("abort_then_unlock", int'(unlock), 1);
    chk("abort_tries", int'(tries_left), 3);
    do_relock();

    // Idle gaps between digits are tolerated.
    dig(4'h1);
    idle(3);
    chk("gap_cnt1", int'(digit_cnt), 1);
    dig(4'h2);
    idle(2);
    chk("gap_cnt2", int'(digit_cnt), 2);
    dig(4'h3);
    dig(4'h4);
    chk("gap_unlock", int'(unlock), 1);
    do_relock();

    // Code reload while open; ignored while locked.
    enter(16'h1234);
    load(16'h9876);
    idle(1);
    do_relock();
    clr_runs();
    enter(16'h1234);
    chk("old_code_fails", f_run, 1);
    enter(16'h9876);
    chk("new_code_unlocks", int'(unlock), 1);
    do_relock();
    load(16'hAAAA);
    enter(16'h9876);
    chk("locked_load_ignored", int'(unlock), 1);

    // Reset mid-unlock restores the default code.
    idle(2);
    do_reset();
    chk("rst_unl_unlock", int'(unlock), 0);
    chk("rst_unl_tries", int'(tries_left), 3);
    enter(16'h1234);
    chk("default_code_back", int'(unlock), 1);
    do_relock();

    // Reset mid-lockout.
    enter(16'h5555);
    enter(16'h5555);
    enter(16'h5555);
    idle(3);
    chk("in_lockout", int'(lockout), 1);
    do_reset();
    chk("rst_lo_lockout", int'(lockout), 0);
    chk("rst_lo_tries", int'(tries_left), 3);
    enter(16'h1234);
    chk("unlock_after_rst", int'(unlock), 1);
    idle(10);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_lock_fsm.md
Name: seq_lock_fsm

Overview:
Sequential, parametrised digital lock; successor to the combinational 4-bit lock. Digits enter one per valid strobe and are compared against a stored, reloadable code. Wrong attempts are counted and force a timed lockout after MAX_TRIES consecutive failures. A correct code opens the lock for a timed window. Sits between keypad debounce/encoder logic and the door actuator driver.

Parameters:
DIGIT_W, 4, bits per digit
CODE_LEN, 4, digits per code (>=1)
DEFAULT_CODE, 16'h1234, code loaded at reset, CODE_LEN*DIGIT_W bits; first digit entered = most significant digit
MAX_TRIES, 3, consecutive failed attempts before lockout (>=1)
UNLOCK_CYC, 8, cycles unlock stays high without relock
LOCKOUT_CYC, 16, cycles spent in lockout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
digit_in  in  DIGIT_W  entered digit
digit_valid  in  1  digit_in valid this cycle
code_load  in  1  write code_in as new code; honoured only while unlocked
code_in  in  CODE_LEN*DIGIT_W  new code, same ordering as DEFAULT_CODE
relock  in  1  close lock immediately
unlock  out  1  lock open
lockout  out  1  lockout in progress; digits ignored
fail_pulse  out  1  one-cycle pulse on a wrong complete code
tries_left  out  $clog2(MAX_TRIES+1)  attempts remaining
digit_cnt  out  $clog2(CODE_LEN+1)  digits accepted in current attempt

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled low on a clk rising edge resets. All outputs registered.
- Reset values: state=LOCKED, code=DEFAULT_CODE, unlock=0, lockout=0, fail_pulse=0, tries_left=MAX_TRIES, digit_cnt=0, mismatch flag=0, timers=0. Reset mid-attempt, mid-unlock or mid-lockout discards all progress. A loaded code is lost; code returns to DEFAULT_CODE.
- States: LOCKED, UNLOCKED, LOCKOUT.
- LOCKED: each edge with digit_valid=1 compares digit_in to code digit[digit_cnt], ORs any mismatch into the mismatch flag and increments digit_cnt. Wrong digits are not reported until the attempt completes.
- Completion is the edge accepting digit CODE_LEN. On that edge digit_cnt->0 and the mismatch flag clears.
  - Match: ->UNLOCKED. unlock=1 in the very next cycle (latency 1 from the final digit). tries_left->MAX_TRIES. Unlock timer loads UNLOCK_CYC-1.
  - Mismatch: fail_pulse=1 for exactly one cycle. tries_left decrements. If it reaches 0 -> LOCKOUT with lockout=1 next cycle and the lockout timer loaded LOCKOUT_CYC-1; otherwise stay LOCKED.
- UNLOCKED: unlock=1. digit_valid ignored.
  - code_load=1 latches code_in; unlock and the timer are unaffected.
  - relock=1, or the timer reaching 0, -> LOCKED with unlock=0 next cycle. This gives exactly UNLOCK_CYC high cycles without relock.
  - relock and code_load in the same cycle: code is written and the lock closes.
- LOCKOUT: lockout=1; digit_valid, code_load and relock ignored. When the timer reaches 0 -> LOCKED with lockout=0 and tries_left=MAX_TRIES. lockout is high for exactly LOCKOUT_CYC cycles.
- code_load outside UNLOCKED is ignored.
- relock in LOCKED aborts a partial attempt: digit_cnt->0, mismatch flag clears, tries_left unchanged. If relock and digit_valid arrive together, relock wins.
- Counters saturate, never wrap. tries_left never goes below 0; digit_cnt never exceeds CODE_LEN-1 while registered.

Decomposition:
- Package seq_lock_pkg holds:
  - state enum: LOCKED, UNLOCKED, LOCKOUT
  - width helpers: CODE_W = CODE_LEN*DIGIT_W, counter widths
  - function to extract digit i from the code vector, MSB-first
- Sub-module lock_timer: loadable down-counter with load, enable and zero flag, width sized for max(UNLOCK_CYC, LOCKOUT_CYC). It is shared by the unlock and lockout states since they are mutually exclusive.
- The remaining FSM and compare logic stay in seq_lock_fsm.

Test Plan:
- Reset, then enter 1,2,3,4 on consecutive cycles -> unlock=1 one cycle after digit 4, high exactly 8 cycles, tries_left=3, fail_pulse never asserted.
- Enter 1,2,3,5 -> fail_pulse a single cycle after digit 4, tries_left=2, unlock=0. Three such attempts -> lockout=1 for exactly 16 cycles, then tries_left=3. Digits 1,2,3,4 sent during lockout -> no unlock.
- Unlock with 1234, code_load with code_in=16'h9876 -> old code fails afterwards (fail_pulse), 9,8,7,6 unlocks. code_load=16'hAAAA while LOCKED -> ignored, 9876 still valid.
- While unlocked, relock after 3 cycles -> unlock=0 next cycle. In LOCKED, enter 1,2 then relock, then 1,2,3,4 -> unlock, tries_left unchanged at 3.
- Enter 1,2 with gaps of idle cycles between digits -> digit_cnt holds at 1 then 2. Completing 3,4 -> unlock (gaps tolerated).
- Assert rst_n=0 for one edge mid-lockout and mid-unlock -> all outputs return to reset values next cycle, code reverts to 16'h1234.
